// File: rtl/ps2_pkg.sv
// ps2_pkg: shared decoder states, PS/2 prefix/error bytes and the key event record
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0_F0} ps2_state_t;
    localparam logic [7:0] PS2_EXTENDED = 8'hE0;
    localparam logic [7:0] PS2_BREAK    = 8'hF0;
    localparam logic [7:0] PS2_ERR0     = 8'h00;
    localparam logic [7:0] PS2_ERR1     = 8'hFF;
    typedef struct packed {
        logic       extended;
        logic       is_release;
        logic [7:0] code;
    } ps2_event_t;
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: small key-event FIFO; a full FIFO still accepts a push when popped in the same cycle
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  ps2_event_t push_data,
    input  logic       pop,
    output ps2_event_t head_data,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    ps2_event_t  mem [FIFO_DEPTH];
    logic        do_pop, do_push;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: turns PS/2 scancode bytes into make/break key events with typematic repeats suppressed
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PREFIX_TIMEOUT = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] scancode_in,
    input  logic       scancode_valid,
    output logic [7:0] event_code,
    output logic       event_release,
    output logic       event_extended,
    output logic       event_valid,
    input  logic       event_ready,
    output logic       overflow
);
    localparam int CW = $clog2(PREFIX_TIMEOUT + 1);
    ps2_state_t  state;
    logic        held_valid, held_ext;
    logic [7:0]  held_code;
    logic [CW-1:0] cnt;
    logic        is_err, is_e0, is_f0, is_data, cand_ext, cand_rel, match, push, empty, full;
    ps2_event_t  cand, head;
    assign is_err   = (scancode_in == PS2_ERR0) || (scancode_in == PS2_ERR1);
    assign is_e0    = scancode_in == PS2_EXTENDED;
    assign is_f0    = scancode_in == PS2_BREAK;
    assign is_data  = ~is_err & ~is_e0 & ~is_f0;
    assign cand_ext = (state == GOT_E0) || (state == GOT_E0_F0);
    assign cand_rel = (state == GOT_F0) || (state == GOT_E0_F0);
    assign match    = held_valid && (held_ext == cand_ext) && (held_code == scancode_in);
    assign cand     = {cand_ext, cand_rel, scancode_in};
    // a make of the key already held is a typematic repeat and produces nothing
    assign push     = scancode_valid & is_data & (cand_rel | ~match);
    ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (cand),
        .pop       (event_ready),
        .head_data (head),
        .empty     (empty),
        .full      (full)
    );
    assign event_valid    = ~empty;
    assign event_code     = head.code;
    assign event_release  = head.is_release;
    assign event_extended = head.extended;
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            held_valid <= 1'b0;
            held_ext   <= 1'b0;
            held_code  <= '0;
            cnt        <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= overflow | (push & full & ~event_ready);
            if (scancode_valid) begin
                cnt   <= '0;
                state <= is_err ? IDLE : is_e0 ? GOT_E0 : is_f0 ? (cand_ext ? GOT_E0_F0 : GOT_F0) : IDLE;
                if (is_data & ~cand_rel & ~match) begin
                    held_valid <= 1'b1;
                    held_ext   <= cand_ext;
                    held_code  <= scancode_in;
                end
                if (is_data & cand_rel & match) held_valid <= 1'b0;
            end else if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt == CW'(PREFIX_TIMEOUT - 1)) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed scancode sequences checked through an expected-event scoreboard
module tb_ps2_key_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] scancode_in = '0;
    logic       scancode_valid = 1'b0;
    logic [7:0] event_code;
    logic       event_release, event_extended, event_valid, overflow;
    logic       event_ready = 1'b0;
    logic [9:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    ps2_key_sequencer #(.FIFO_DEPTH(4), .PREFIX_TIMEOUT(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .scancode_in    (scancode_in),
        .scancode_valid (scancode_valid),
        .event_code     (event_code),
        .event_release  (event_release),
        .event_extended (event_extended),
        .event_valid    (event_valid),
        .event_ready    (event_ready),
        .overflow       (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        scancode_in    = b;
        scancode_valid = 1'b1;
        @(posedge clock);
        #1;
        scancode_valid = 1'b0;
        scancode_in    = '0;
    endtask

    task automatic expect_ev(input logic ext, input logic rel, input logic [7:0] code);
        exp_q.push_back({ext, rel, code});
    endtask

    task automatic drain();
        int n = 0;
        event_ready = 1'b1;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        event_ready = 1'b0;
        chk("drained_valid", event_valid, 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                if (!reset && event_valid && event_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", {event_extended, event_release, event_code}, 10'h3FF);
                    end else begin
                        chk("event", {event_extended, event_release, event_code}, exp_q.pop_front());
                    end
                end
            end
        join_none
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_valid", event_valid, 0);
        chk("rst_head", {event_extended, event_release, event_code}, 0);
        chk("rst_overflow", overflow, 0);
        // single make: visible the cycle after the strobe
        strobe(8'h1C);
        chk("lat_valid", event_valid, 1);
        chk("lat_head", {event_extended, event_release, event_code}, {2'b00, 8'h1C});
        expect_ev(0, 0, 8'h1C);
        drain();
        chk("idle_head", {event_extended, event_release, event_code}, 0);
        // make, break, then a fresh make since held was cleared
        event_ready = 1'b1;
        expect_ev(0, 1, 8'h1C);
        expect_ev(0, 0, 8'h1C);
        strobe(8'hF0); strobe(8'h1C); strobe(8'h1C);
        drain();
        // extended make/break and error byte aborting a prefix
        expect_ev(1, 0, 8'h75);
        expect_ev(1, 1, 8'h75);
        expect_ev(0, 0, 8'h75);
        strobe(8'hE0); strobe(8'h75);
        strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
        strobe(8'hE0); strobe(8'hFF); strobe(8'h75);
        drain();
        // typematic repeats
        expect_ev(0, 0, 8'h1C);
        expect_ev(0, 1, 8'h1C);
        expect_ev(0, 0, 8'h1C);
        strobe(8'h1C); strobe(8'h1C); strobe(8'h1C);
        strobe(8'hF0); strobe(8'h1C); strobe(8'h1C);
        drain();
        expect_ev(0, 1, 8'h1C);
        strobe(8'hF0); strobe(8'h1C);
        drain();
        // overflow with ready low
        expect_ev(0, 0, 8'h1C);
        expect_ev(0, 0, 8'h1B);
        expect_ev(0, 0, 8'h23);
        expect_ev(0, 0, 8'h2B);
        strobe(8'h1C); strobe(8'h1B); strobe(8'h23); strobe(8'h2B);
        chk("full_no_ovf", overflow, 0);
        strobe(8'h34);
        chk("overflow_set", overflow, 1);
        chk("full_head", {event_extended, event_release, event_code}, {2'b00, 8'h1C});
        expect_ev(0, 0, 8'h35);
        event_ready = 1'b1;
        strobe(8'h35);
        event_ready = 1'b0;
        chk("push_pop_head", event_code, 8'h1B);
        drain();
        chk("ovf_sticky", overflow, 1);
        // prefix timeout: F0 abandoned after 16 idle cycles
        expect_ev(0, 0, 8'h1C);
        strobe(8'hF0);
        repeat (16) @(posedge clock);
        #1;
        strobe(8'h1C);
        drain();
        // one cycle short of the timeout the prefix still applies
        expect_ev(0, 1, 8'h1C);
        strobe(8'hF0);
        repeat (15) @(posedge clock);
        #1;
        strobe(8'h1C);
        drain();
        // reset mid-sequence discards the F0
        strobe(8'hF0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_ovf", overflow, 0);
        chk("reset_valid", event_valid, 0);
        expect_ev(0, 0, 8'h1C);
        strobe(8'h1C);
        chk("post_reset_head", {event_extended, event_release, event_code}, {2'b00, 8'h1C});
        drain();
        chk("final_queue", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
